// File: rtl/ram_pkg.sv
// Shared definitions for the single-port byte-enable RAM and its clear sequencer.
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the lane-merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_MAX_W = 1024;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ram_state_e;

    // Lanes with be set come from new_word, the rest keep old_word.
    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_W-1:0] be,
        input int unsigned            byte_w
    );
        logic [MERGE_MAX_W-1:0] res;
        int unsigned            lane;
        res = old_word;
        for (int unsigned b = 0; b < MERGE_MAX_W; b++) begin
            lane = b / byte_w;
            if (be[lane]) begin
                res[b] = new_word[b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every word address once, writing zero.
// Latency: busy rises with the reset edge and drops DEPTH edges after rst falls.
// Backpressure: none taken; busy tells the RAM front end to reject requests.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 1024,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_e        state_d, state_q;
    logic [ADDR_W-1:0] clr_cnt_d, clr_cnt_q;
    logic              busy_d, busy_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        end
        busy_d = (state_d == ST_CLEAR);
    end

    // Reset mid-clear lands here too, so the walk restarts from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt_q <= '0;
            busy_q    <= (CLEAR_ON_RST != 0);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_we   = (state_q == ST_CLEAR) && !rst;
    assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/ram_sp_be_sync.sv
// Single-port synchronous RAM with byte-lane writes and selectable read-during-write.
// Latency: read data and rd_valid appear 1 + OUT_REG edges after the request edge.
// Backpressure: none; requests during the post-reset clear are dropped and flagged on err.
module ram_sp_be_sync
    import ram_pkg::*;
#(
    parameter int  ADDR_W       = 10,
    parameter int  DEPTH        = 1024,
    parameter int  DATA_W       = 32,
    parameter int  BYTE_W       = 8,
    parameter int  OUT_REG      = 1,
    parameter int  RDW_MODE     = 0,
    parameter int  CLEAR_ON_RST = 1,
    localparam int NB           = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NB-1:0]     be,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              req, oor, acc_wr, acc_rd;
    logic [DATA_W-1:0] old_word, wr_word, rd_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdat;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              rd1_vld_d, rd1_vld_q;
    logic [DATA_W-1:0] rd1_dat_d, rd1_dat_q;
    logic              err_d, err_q;

    ram_clear_seq #(
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .CLEAR_ON_RST (CLEAR_ON_RST)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    always_comb begin
        req    = cs && (we || re);
        oor    = {1'b0, addr} >= (ADDR_W + 1)'(DEPTH);
        acc_wr = req && we && !busy && !oor && !rst;
        acc_rd = req && re && !busy && !rst;
        err_d  = req && (busy || oor);

        // Out-of-range reads return zero rather than whatever the array index aliases to.
        old_word = oor ? '0 : mem_q[addr];
        wr_word  = DATA_W'(lane_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(wdata),
                                      MERGE_MAX_W'(be), BYTE_W));
        rd_word  = ((RDW_MODE == RDW_WRITE_FIRST) && acc_wr) ? wr_word : old_word;

        // Clear and user writes never overlap: busy blocks user requests.
        mem_we   = clr_we || acc_wr;
        mem_addr = clr_we ? clr_addr : addr;
        mem_wdat = clr_we ? '0 : wr_word;

        rd1_vld_d = acc_rd;
        rd1_dat_d = acc_rd ? rd_word : rd1_dat_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_vld_q <= 1'b0;
            rd1_dat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rd1_vld_q <= rd1_vld_d;
            rd1_dat_q <= rd1_dat_d;
            err_q     <= err_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              rd2_vld_d, rd2_vld_q;
            logic [DATA_W-1:0] rd2_dat_d, rd2_dat_q;

            always_comb begin
                rd2_vld_d = rd1_vld_q;
                rd2_dat_d = rd1_vld_q ? rd1_dat_q : rd2_dat_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd2_vld_q <= 1'b0;
                    rd2_dat_q <= '0;
                end else begin
                    rd2_vld_q <= rd2_vld_d;
                    rd2_dat_q <= rd2_dat_d;
                end
            end

            assign rd_valid = rd2_vld_q;
            assign rdata    = rd2_dat_q;
        end else begin : g_no_out_reg
            assign rd_valid = rd1_vld_q;
            assign rdata    = rd1_dat_q;
        end
    endgenerate

    assign err = err_q;

endmodule

// File: tb/tb_ram_sp_be_sync.sv
// Two RAM instances (16 words/latency 2/read-first, 12 words/latency 1/write-first)
// share one stimulus stream; a reference model predicts busy, err and read returns.
module tb_ram_sp_be_sync;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, we = 1'b0, re = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;

    logic [31:0] rdata_a, rdata_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b, err_a, err_b;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          chk_on = 1'b0;

    int          dep[2]    = '{16, 12};
    int          outreg[2] = '{1, 0};
    bit          rdw[2]    = '{1'b0, 1'b1};
    logic [31:0] mm[2][16];
    int          clr_cnt[2];
    bit          exp_err[2];
    logic [31:0] last_rd[2];
    exp_t        q_a[$];
    exp_t        q_b[$];

    always #5 clk = ~clk;

    ram_sp_be_sync #(
        .ADDR_W(4), .DEPTH(16), .DATA_W(32), .BYTE_W(8),
        .OUT_REG(1), .RDW_MODE(0), .CLEAR_ON_RST(1)
    ) dut_a (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .re(re), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata_a), .rd_valid(rd_valid_a),
        .busy(busy_a), .err(err_a)
    );

    ram_sp_be_sync #(
        .ADDR_W(4), .DEPTH(12), .DATA_W(32), .BYTE_W(8),
        .OUT_REG(0), .RDW_MODE(1), .CLEAR_ON_RST(1)
    ) dut_b (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .re(re), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata_b), .rd_valid(rd_valid_b),
        .busy(busy_b), .err(err_b)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_step(input int k);
        logic [31:0] old_w, new_w;
        bit          busy_now, oor, req;
        exp_t        e;
        if (rst) begin
            clr_cnt[k] = dep[k];
            exp_err[k] = 1'b0;
            last_rd[k] = '0;
            for (int j = 0; j < 16; j++) mm[k][j] = '0;
            if (k == 0) q_a.delete(); else q_b.delete();
            return;
        end
        busy_now = clr_cnt[k] > 0;
        if (busy_now) clr_cnt[k]--;
        req = cs && (we || re);
        oor = int'(addr) >= dep[k];
        exp_err[k] = req && (busy_now || oor);
        if (req && !busy_now) begin
            old_w = oor ? 32'h0 : mm[k][addr];
            new_w = merge(old_w, wdata, be);
            if (re) begin
                e.due = cyc + outreg[k];
                e.dat = oor ? 32'h0 : ((rdw[k] && we) ? new_w : old_w);
                if (k == 0) q_a.push_back(e); else q_b.push_back(e);
            end
            if (we && !oor) mm[k][addr] = new_w;
        end
    endtask

    task automatic check_dut(input int k, input string nm, input logic rdv,
                             input logic [31:0] rdat, input logic bsy, input logic er);
        exp_t e;
        bit   due;
        chk_val({nm, " busy"}, 32'(bsy), 32'(clr_cnt[k] > 0));
        chk_val({nm, " err"}, 32'(er), 32'(exp_err[k]));
        if (k == 0) due = (q_a.size() > 0) && (q_a[0].due == cyc);
        else        due = (q_b.size() > 0) && (q_b[0].due == cyc);
        if (due) begin
            if (k == 0) e = q_a.pop_front(); else e = q_b.pop_front();
            chk_val({nm, " rd_valid"}, 32'(rdv), 32'h1);
            chk_val({nm, " rdata"}, rdat, e.dat);
            last_rd[k] = e.dat;
        end else begin
            chk_val({nm, " rd_valid idle"}, 32'(rdv), 32'h0);
            chk_val({nm, " rdata hold"}, rdat, last_rd[k]);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) chk_on = 1'b1;
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_dut(0, "A", rd_valid_a, rdata_a, busy_a, err_a);
            check_dut(1, "B", rd_valid_b, rdata_b, busy_b, err_b);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cs = 1'b0; we = 1'b0; re = 1'b0;
        end
    endtask

    task automatic req_op(input bit w, input bit r, input logic [3:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        cs = 1'b1; we = w; re = r; addr = a; wdata = d; be = b;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Requests during the clear: one selected (rejected), one deselected.
        idle(2);
        req_op(1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
        req_op(1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
        cs = 1'b0;
        idle(20);

        for (int a = 0; a < 16; a++) req_op(1'b0, 1'b1, 4'(a), 32'h0, 4'h0);
        idle(3);

        req_op(1'b1, 1'b0, 4'd5, 32'hAABBCCDD, 4'b1111);
        req_op(1'b1, 1'b0, 4'd5, 32'h11223344, 4'b0101);
        req_op(1'b0, 1'b1, 4'd5, 32'h0, 4'h0);
        req_op(1'b1, 1'b0, 4'd6, 32'h55667788, 4'b0000);
        req_op(1'b0, 1'b1, 4'd6, 32'h0, 4'h0);
        idle(3);

        req_op(1'b1, 1'b0, 4'd7, 32'h01020304, 4'b1111);
        req_op(1'b1, 1'b1, 4'd7, 32'hFFFFFFFF, 4'b0011);
        req_op(1'b0, 1'b1, 4'd7, 32'h0, 4'h0);
        idle(3);

        req_op(1'b1, 1'b0, 4'd13, 32'hDEADBEEF, 4'b1111);
        req_op(1'b0, 1'b1, 4'd13, 32'h0, 4'h0);
        req_op(1'b1, 1'b1, 4'd14, 32'h12345678, 4'b1111);
        idle(3);

        repeat (300) begin
            @(negedge clk);
            cs    = ($urandom_range(0, 3) != 0);
            we    = 1'($urandom_range(0, 1));
            re    = 1'($urandom_range(0, 1));
            addr  = 4'($urandom_range(0, 15));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
        end
        idle(3);

        // Streaming reads interrupted by reset after the eighth request.
        for (int a = 0; a < 8; a++) req_op(1'b0, 1'b1, 4'(a), 32'h0, 4'h0);
        @(negedge clk);
        cs = 1'b0; re = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        for (int a = 0; a < 16; a++) req_op(1'b0, 1'b1, 4'(a), 32'h0, 4'h0);
        idle(4);

        chk_val("A queue drained", 32'(q_a.size()), 32'h0);
        chk_val("B queue drained", 32'(q_b.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_sp_be_sync.md
Name: ram_sp_be_sync

Overview:
Parametrised single-port synchronous RAM with byte-lane write enables and a defined read-during-write mode.
- Optional output register stage.
- Post-reset hardware clear sequencer, with busy and error reporting.
- Serves as the generic on-chip buffer/scratchpad used by datapath blocks. Sits directly behind a bus or controller issuing cs/we/re requests.

Parameters:
ADDR_W, 10, address width
DEPTH, 1024, number of words; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_W
DATA_W, 32, word width; must be a multiple of BYTE_W
BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes
OUT_REG, 1, 0 = read latency 1, 1 = extra output register (latency 2)
RDW_MODE, 0, 0 = read-first (old data), 1 = write-first (merged new data)
CLEAR_ON_RST, 1, 1 = zero all words after reset; 0 = contents untouched by reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
cs  in  1  chip select; no request is taken when low
we  in  1  write request
re  in  1  read request
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
be  in  NB  byte enables; lane i = wdata[i*BYTE_W +: BYTE_W]
rdata  out  DATA_W  read data
rd_valid  out  1  one-cycle strobe; rdata valid for this read
busy  out  1  clear sequencer running; requests rejected
err  out  1  one-cycle pulse flagging a rejected or out-of-range request

Behaviour:
Interface: one clock (clk); reset rst is synchronous and active-high.

Reset (rst=1 at an edge):
- rdata=0, rd_valid=0, err=0; all pipeline valid bits cleared.
- clr_cnt=0.
- busy=1 if CLEAR_ON_RST, else busy=0.
- Asserting rst mid-clear restarts the clear from address 0.

States: CLEAR, IDLE.
- CLEAR: each edge with rst=0 writes mem[clr_cnt]=0 and increments clr_cnt. The edge that writes DEPTH-1 moves to IDLE. busy is high for exactly DEPTH cycles after rst falls.
- IDLE: busy=0; requests serviced.

Request acceptance:
- A request is sampled at edge N when cs=1 and (we|re).
- busy=1 -> request dropped: no write, no rd_valid, err=1 after edge N.
- cs=0 -> nothing happens, no err.

Write (we=1, accepted):
- At edge N, only lanes with be[i]=1 are updated.
- be=0 is a legal no-op write.

Read (re=1, accepted):
- rdata and rd_valid=1 are updated at edge N+OUT_REG.
- rd_valid is high for exactly one cycle per accepted read.
- Back-to-back reads every cycle are allowed, giving a continuous rd_valid stream.
- rdata holds its last value while rd_valid=0.

Simultaneous we=1 and re=1 (same address, single port):
- Both operations are performed; no error.
- RDW_MODE=0: read returns the pre-write word.
- RDW_MODE=1: read returns enabled lanes from wdata and other lanes from the old word.

Out-of-range address (addr ≥ DEPTH, only possible when DEPTH < 2**ADDR_W):
- Write is dropped.
- Read still produces rd_valid with rdata=0.
- err=1 after edge N.

Other rules:
- err is registered and never asserted by reset.
- Memory contents are undefined before the first clear when CLEAR_ON_RST=0.

Decomposition:
- Shared package ram_pkg:
  - constants RDW_READ_FIRST=0, RDW_WRITE_FIRST=1;
  - state encoding ST_IDLE, ST_CLEAR;
  - a lane-merge function (old, new, be) -> word, used for both the write path and RDW_MODE=1.
- Sub-module ram_clear_seq: clr_cnt counter, state register, busy output, clear write strobe/address. The top muxes its address and write port into the array.

Test Plan:
1. DEPTH=16, CLEAR_ON_RST=1: hold rst 3 cycles, release -> busy=1 for exactly 16 cycles. Reads of all 16 addresses then return 0x00000000.
2. During busy, cs=1, re=1, addr=3 -> no rd_valid, err pulses once. Again with cs=0 -> no err.
3. Write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101, then read -> 0xAA22CC44. rd_valid appears 1 edge (OUT_REG=0) or 2 edges (OUT_REG=1) after the request edge.
4. mem[7]=0x01020304; same-cycle we=1, re=1, wdata=0xFFFFFFFF, be=4'b0011 -> RDW_MODE=0 returns 0x01020304, RDW_MODE=1 returns 0x0102FFFF. A follow-up read returns 0x0102FFFF in both modes.
5. Read addr 0..15 on consecutive cycles -> 16 consecutive rd_valid cycles with correct data order. Assert rst after the 8th -> no rd_valid after reset, and busy restarts for 16 cycles.
6. DEPTH=12, ADDR_W=4: write addr 13 -> err pulse, no array change. Read addr 13 -> rd_valid with rdata=0, err pulse.
